ex_fp_unit: RTL and testbench



---
 rtl/ex_fp_if.sv | 26 ++
 rtl/ex_fp_unit.sv | 187 ++++++++++++++++++
 tb/tb_ex_fp_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ex_fp_if.sv
// Handshake and result bus between the ID/EX register and the FP execute unit.
interface ex_fp_if #(
  parameter int TAG_W = 6
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [31:0]      a_i;
  logic [31:0]      b_i;
  logic [TAG_W-1:0] tag_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      result_o;
  logic [TAG_W-1:0] tag_o;
  logic [2:0]       flags_o;

  modport master (
    output start_i, op_i, a_i, b_i, tag_i,
    input  stall_o, busy_o, done_o, result_o, tag_o, flags_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, tag_i,
    output stall_o, busy_o, done_o, result_o, tag_o, flags_o
  );
endinterface

// File: rtl/ex_fp_unit.sv
// Multi-cycle single-precision add/sub/mul for the EX stage; stalls the
// front of the pipeline while it iterates and truncates its results.
//
// state   | meaning
// IDLE    | waiting for start_i
// UNPACK  | split captured operands, flush denormals, flip B sign for sub
// ALIGN   | order by magnitude, shift smaller significand right
// ADDSUB  | add or subtract aligned significands
// MULITER | one shift-add step of the significand product per cycle
// NORM    | leading-one normalise, pack, classify special cases
// DONE    | result valid for one cycle; may accept the next request
module ex_fp_unit #(
  parameter int TAG_W     = 6,
  parameter int MUL_ITERS = 24
) (
  input logic   clk,
  input logic   reset,
  ex_fp_if.slave bus
);
  localparam int CNT_W = $clog2(MUL_ITERS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_MULITER, S_NORM, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]       a_q, b_q;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q, tago_q;
  logic              sa_q, sb_q, sign_q, inv_q;
  logic [7:0]        ea_q, eb_q;
  logic [23:0]       ma_q, mb_q;
  logic signed [9:0] exp_q;
  logic [47:0]       man_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       result_q;
  logic [2:0]        flags_q;

  logic              accept;
  logic [7:0]        ea_w, eb_w, e_l, e_s, e_diff;
  logic              swap, s_l, s_s, sum_sign, mul_bit;
  logic [23:0]       m_l, m_s, m_s_sh;
  logic [24:0]       sum_w;
  logic [47:0]       partial;
  logic [5:0]        lead, shl;
  logic [22:0]       frac_w;
  logic signed [9:0] norm_e;
  logic [31:0]       res_w;
  logic [2:0]        flags_w;

  assign accept = bus.start_i & ((state_q == S_IDLE) | (state_q == S_DONE));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.start_i) state_d = S_UNPACK;
      S_UNPACK:  state_d = (op_q == 2'b10) ? S_MULITER : S_ALIGN;
      S_ALIGN:   state_d = S_ADDSUB;
      S_ADDSUB:  state_d = S_NORM;
      S_MULITER: if (cnt_q == CNT_W'(MUL_ITERS - 1)) state_d = S_NORM;
      S_NORM:    state_d = S_DONE;
      S_DONE:    state_d = bus.start_i ? S_UNPACK : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath combinational helpers for each step.
  always_comb begin
    ea_w   = a_q[30:23];
    eb_w   = b_q[30:23];
    swap   = {eb_q, mb_q} > {ea_q, ma_q};
    e_l    = swap ? eb_q : ea_q;
    e_s    = swap ? ea_q : eb_q;
    m_l    = swap ? mb_q : ma_q;
    m_s    = swap ? ma_q : mb_q;
    s_l    = swap ? sb_q : sa_q;
    s_s    = swap ? sa_q : sb_q;
    e_diff = e_l - e_s;
    m_s_sh = (e_diff >= 8'd26) ? 24'd0 : (m_s >> e_diff);
    // ALIGN leaves the larger magnitude in A, so the difference is never negative.
    if (sa_q == sb_q) begin
      sum_w    = {1'b0, ma_q} + {1'b0, mb_q};
      sum_sign = sa_q;
    end else begin
      sum_w    = {1'b0, ma_q} - {1'b0, mb_q};
      sum_sign = (sum_w == 25'd0) ? 1'b0 : sa_q;
    end
    mul_bit = |(mb_q & (24'd1 << cnt_q));
    partial = {24'd0, ma_q} << cnt_q;
    // Binary point of man_q sits between bits 46 and 45.
    lead = 6'd0;
    for (int i = 0; i < 48; i++) if (man_q[i]) lead = 6'(i);
    shl = 6'd0;
    if (lead == 6'd47) begin
      frac_w = man_q[46:24];
      norm_e = exp_q + 10'sd1;
    end else begin
      shl    = 6'd46 - lead;
      frac_w = 23'((man_q << shl) >> 23);
      norm_e = exp_q - $signed({4'd0, shl});
    end
    if (op_q == 2'b11) begin
      res_w = 32'd0;                        flags_w = 3'b100;
    end else if (inv_q) begin
      res_w = 32'h7FC0_0000;                flags_w = 3'b100;
    end else if (man_q == 48'd0) begin
      res_w = {sign_q, 31'd0};              flags_w = 3'b001;
    end else if (norm_e >= 10'sd255) begin
      res_w = {sign_q, 8'hFF, 23'd0};       flags_w = 3'b010;
    end else if (norm_e <= 10'sd0) begin
      res_w = {sign_q, 31'd0};              flags_w = 3'b001;
    end else begin
      res_w = {sign_q, norm_e[7:0], frac_w}; flags_w = 3'b000;
    end
  end

  // Operand capture, per-state datapath registers and held outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0; b_q <= '0; op_q <= '0; tag_q <= '0; tago_q <= '0;
      sa_q <= 1'b0; sb_q <= 1'b0; sign_q <= 1'b0; inv_q <= 1'b0;
      ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      exp_q <= '0; man_q <= '0; cnt_q <= '0;
      result_q <= '0; flags_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= bus.a_i;
        b_q   <= bus.b_i;
        op_q  <= bus.op_i;
        tag_q <= bus.tag_i;
      end
      case (state_q)
        S_UNPACK: begin
          sa_q   <= a_q[31];
          sb_q   <= b_q[31] ^ (op_q == 2'b01);
          sign_q <= a_q[31] ^ b_q[31];
          ea_q   <= ea_w;
          eb_q   <= eb_w;
          ma_q   <= (ea_w == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
          mb_q   <= (eb_w == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
          inv_q  <= (op_q == 2'b11) | (ea_w == 8'hFF) | (eb_w == 8'hFF);
          exp_q  <= $signed({2'b00, ea_w}) + $signed({2'b00, eb_w}) - 10'sd127;
          man_q  <= '0;
          cnt_q  <= '0;
        end
        S_ALIGN: begin
          sa_q  <= s_l;
          sb_q  <= s_s;
          ma_q  <= m_l;
          mb_q  <= m_s_sh;
          exp_q <= $signed({2'b00, e_l});
        end
        S_ADDSUB: begin
          man_q  <= {sum_w, 23'd0};
          sign_q <= sum_sign;
        end
        S_MULITER: begin
          if (mul_bit) man_q <= man_q + partial;
          cnt_q <= cnt_q + 1'b1;
        end
        S_NORM: begin
          result_q <= res_w;
          flags_q  <= flags_w;
          tago_q   <= tag_q;
        end
        default: ;
      endcase
    end
  end

  // The DONE cycle never stalls, so the pipeline advances exactly once per result.
  assign bus.stall_o  = (~reset & (state_q == S_IDLE) & bus.start_i) |
                        ((state_q != S_IDLE) & (state_q != S_DONE));
  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;
  assign bus.tag_o    = tago_q;
  assign bus.flags_o  = flags_q;
endmodule

// File: tb/tb_ex_fp_unit.sv
// Directed bench for ex_fp_unit with a scoreboard of expected results.
module tb_ex_fp_unit;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [2:0]  flags;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  ex_fp_if #(.TAG_W(6)) bus_if ();

  ex_fp_unit #(.TAG_W(6), .MUL_ITERS(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Result monitor: pops the scoreboard on every done pulse.
  always begin
    @(negedge clk);
    #2;
    if (!reset && bus_if.done_o === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", bus_if.result_o, e.res);
        chk("tag", 32'(bus_if.tag_o), 32'(e.tag));
        chk("flags", 32'(bus_if.flags_o), 32'(e.flags));
        chk("latency", 32'(cyc), 32'(e.done_cyc));
      end
      chk("stall_in_done", 32'(bus_if.stall_o), 32'd0);
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] res,
                       input logic [2:0] flags, input int lat);
    exp_t e;
    bus_if.op_i    = op;
    bus_if.a_i     = a;
    bus_if.b_i     = b;
    bus_if.tag_i   = tag;
    bus_if.start_i = 1'b1;
    e.res = res; e.tag = tag; e.flags = flags; e.done_cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // Issue from IDLE: checks the accept-cycle stall, then drops start.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] res,
                       input logic [2:0] flags, input int lat);
    drive(op, a, b, tag, res, flags, lat);
    #1;
    chk("stall_accept", 32'(bus_if.stall_o), 32'd1);
    @(negedge clk);
    bus_if.start_i = 1'b0;
  endtask

  task automatic run_to_done(input int lat);
    int  stalls = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_if.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus_if.stall_o === 1'b1) stalls++;
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(lat - 1));
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_stall"},  32'(bus_if.stall_o), 32'd0);
    chk({tag, "_busy"},   32'(bus_if.busy_o), 32'd0);
    chk({tag, "_done"},   32'(bus_if.done_o), 32'd0);
    chk({tag, "_result"}, bus_if.result_o, 32'd0);
    chk({tag, "_tag"},    32'(bus_if.tag_o), 32'd0);
    chk({tag, "_flags"},  32'(bus_if.flags_o), 32'd0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    bus_if.start_i = 1'b0;
    bus_if.op_i    = 2'b00;
    bus_if.a_i     = 32'd0;
    bus_if.b_i     = 32'd0;
    bus_if.tag_i   = 6'd0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'h3F80_0000, 32'h4000_0000, 6'd5, 32'h4040_0000, 3'b000, 5);
    run_to_done(5);
    issue(2'b01, 32'h4040_0000, 32'h4040_0000, 6'd6, 32'h0000_0000, 3'b001, 5);
    run_to_done(5);
    issue(2'b10, 32'h3FC0_0000, 32'h4020_0000, 6'd7, 32'h4070_0000, 3'b000, 27);
    run_to_done(27);
    issue(2'b10, 32'h7F00_0000, 32'h7F00_0000, 6'd8, 32'h7F80_0000, 3'b010, 27);
    run_to_done(27);
    issue(2'b00, 32'h7F80_0000, 32'h3F80_0000, 6'd9, 32'h7FC0_0000, 3'b100, 5);
    run_to_done(5);
    issue(2'b11, 32'h3F80_0000, 32'h3F80_0000, 6'd10, 32'h0000_0000, 3'b100, 5);
    run_to_done(5);
    issue(2'b10, 32'h8000_0000, 32'h4000_0000, 6'd11, 32'h8000_0000, 3'b001, 27);
    run_to_done(27);
    issue(2'b01, 32'h3F80_0000, 32'h4000_0000, 6'd16, 32'hBF80_0000, 3'b000, 5);
    run_to_done(5);
    issue(2'b10, 32'h0080_0000, 32'h0080_0000, 6'd15, 32'h0000_0000, 3'b001, 27);
    run_to_done(27);

    // start held high with churning operands during a mul, then back-to-back add.
    drive(2'b10, 32'h3FC0_0000, 32'h4020_0000, 6'd12, 32'h4070_0000, 3'b000, 27);
    #1;
    chk("b2b_stall_accept", 32'(bus_if.stall_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus_if.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      bus_if.a_i   = $urandom;
      bus_if.b_i   = $urandom;
      bus_if.op_i  = 2'($urandom_range(0, 3));
      bus_if.tag_i = 6'($urandom_range(0, 63));
    end
    chk("b2b_mul_done_seen", 32'(seen), 32'd1);
    drive(2'b00, 32'h3F80_0000, 32'h4000_0000, 6'd13, 32'h4040_0000, 3'b000, 5);
    @(negedge clk);
    bus_if.start_i = 1'b0;
    run_to_done(5);

    // Reset while the multiply counter is at 10.
    issue(2'b10, 32'h3FC0_0000, 32'h4020_0000, 6'd3, 32'h4070_0000, 3'b000, 27);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(2'b00, 32'h4000_0000, 32'h4000_0000, 6'd14, 32'h4080_0000, 3'b000, 5);
    run_to_done(5);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
